// File: rtl/partial_product_stage.sv
// Two-stage pipelined partial-product generator feeding the adder tree.
// Stage 1 registers the operands; stage 2 registers the packed, shifted partial products.
module partial_product_stage #(
  parameter int unsigned SIZE          = 4,
  parameter int unsigned OPERAND_WIDTH = 4,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OPERAND_WIDTH-1:0]   multiplicand,
  input  logic [SIZE-1:0]            multiplier,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIZE*DATA_WIDTH-1:0] partial_products,
  output logic [1:0]                 in_flight
);

  logic                       r_s1_valid;
  logic                       r_s2_valid;
  logic [OPERAND_WIDTH-1:0]   r_a;
  logic [SIZE-1:0]            r_b;
  logic [SIZE*DATA_WIDTH-1:0] r_pp;

  logic                       w_s2_accept;
  logic                       w_s1_adv;
  logic                       w_in_accept;
  logic [DATA_WIDTH-1:0]      w_a_ext;
  logic [SIZE*DATA_WIDTH-1:0] w_pp;

  assign w_s2_accept = !r_s2_valid || out_ready;
  assign w_s1_adv    = !r_s1_valid || w_s2_accept;
  assign in_ready    = w_s1_adv && !flush;
  assign w_in_accept = in_valid && in_ready;
  assign w_a_ext     = DATA_WIDTH'(r_a);

  // Bits shifted beyond DATA_WIDTH are intentionally dropped.
  always_comb begin
    w_pp = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      if (r_b[i]) begin
        w_pp[i*DATA_WIDTH +: DATA_WIDTH] = w_a_ext << i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_pp       <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= w_in_accept;
      end
      if (w_in_accept) begin
        r_a <= multiplicand;
        r_b <= multiplier;
      end
      if (w_s2_accept) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_pp <= w_pp;
        end
      end
    end
  end

  assign out_valid        = r_s2_valid;
  assign partial_products = r_pp;
  assign in_flight        = {1'b0, r_s1_valid} + {1'b0, r_s2_valid};

endmodule
